// File: rtl/av_demo_core.sv
// VGA timing + four frame-latched test patterns + line-rate sawtooth PWM audio.
// Every output is registered one clock behind the raster counters it derives from.
module av_demo_core #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLOR_W   = 2,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned STEP_BASE = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         vga_state,
  input  logic [SEL_W-1:0]   audio_select,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_tick,
  output logic               pwm_out
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_LEN  = H_ACTIVE / 8;
  localparam int unsigned BAR_CW   = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam int unsigned GRAD_SH  = $clog2(H_ACTIVE) - COLOR_W;
  localparam int unsigned HV_W     = (HW > VW) ? HW : VW;
  // Scroll sums wrap at the wider of the raster counters and the 8-bit frame count.
  localparam int unsigned SUM_W    = (HV_W > 8) ? HV_W : 8;

  logic [HW-1:0]      h;
  logic [VW-1:0]      v;
  logic [1:0]         mode;
  logic [7:0]         fc;
  logic [BAR_CW-1:0]  bar_sub;
  logic [2:0]         bar_k;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   step_c;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   duty;
  logic               h_last_c;
  logic               v_last_c;
  logic               active_c;
  logic               hs_c;
  logic               vs_c;
  logic               chk_c;
  logic [SUM_W-1:0]   hsum_c;
  logic [SUM_W-1:0]   vsum_c;
  logic [COLOR_W-1:0] r_c;
  logic [COLOR_W-1:0] g_c;
  logic [COLOR_W-1:0] b_c;

  assign h_last_c = (h == HW'(H_TOTAL - 1));
  assign v_last_c = (v == VW'(V_TOTAL - 1));
  assign active_c = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign hs_c     = !((h >= HW'(HS_START)) && (h < HW'(HS_END)));
  assign vs_c     = !((v >= VW'(VS_START)) && (v < VW'(VS_END)));
  assign chk_c    = h[5] ^ v[5];
  assign hsum_c   = SUM_W'(h) + SUM_W'(fc);
  assign vsum_c   = SUM_W'(v) + SUM_W'(fc);
  assign step_c   = ACC_W'(audio_select) * ACC_W'(STEP_BASE);

  // Raster counters, frame-end mode latch and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h    <= '0;
      v    <= '0;
      mode <= '0;
      fc   <= '0;
    end else begin
      h <= h_last_c ? '0 : h + HW'(1);
      if (h_last_c) begin
        v <= v_last_c ? '0 : v + VW'(1);
        if (v_last_c) begin
          mode <= vga_state;
          fc   <= fc + 8'd1;
        end
      end
    end
  end

  // Bar index tracks h without a divider; both are zero whenever h is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_sub <= '0;
      bar_k   <= '0;
    end else if (h_last_c) begin
      bar_sub <= '0;
      bar_k   <= '0;
    end else if (bar_sub == BAR_CW'(BAR_LEN - 1)) begin
      bar_sub <= '0;
      bar_k   <= bar_k + 3'd1;
    end else begin
      bar_sub <= bar_sub + BAR_CW'(1);
    end
  end

  // Pattern colour for the current counter position.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (mode)
      2'd0: begin
        r_c = {COLOR_W{bar_k[2]}};
        g_c = {COLOR_W{bar_k[1]}};
        b_c = {COLOR_W{bar_k[0]}};
      end
      2'd1: begin
        r_c = {COLOR_W{chk_c}};
        g_c = {COLOR_W{chk_c}};
        b_c = {COLOR_W{chk_c}};
      end
      2'd2: begin
        r_c = COLOR_W'(h >> GRAD_SH);
        g_c = COLOR_W'(h >> GRAD_SH);
        b_c = COLOR_W'(h >> GRAD_SH);
      end
      default: begin
        r_c = COLOR_W'(hsum_c >> 4);
        g_c = COLOR_W'(vsum_c >> 4);
        b_c = r_c ^ g_c;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vga_r      <= active_c ? r_c : '0;
      vga_g      <= active_c ? g_c : '0;
      vga_b      <= active_c ? b_c : '0;
      hsync      <= hs_c;
      vsync      <= vs_c;
      de         <= active_c;
      frame_tick <= (h == '0) && (v == '0);
    end
  end

  // Sawtooth phase steps once per line; duty reloads only at PWM wrap using pre-step acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (audio_select == '0) begin
        acc <= '0;
      end else if (h_last_c) begin
        acc <= acc + step_c;
      end
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == {PWM_W{1'b1}}) begin
        duty <= acc[ACC_W-1 -: PWM_W];
      end
      pwm_out <= (audio_select != '0) && (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_av_demo_core.sv
// Bench for av_demo_core on a shrunken raster, checked against a frame-position model.
module tb_av_demo_core;

  localparam int HA = 64, HF = 4, HS = 6, HB = 6;
  localparam int VA = 40, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HS_START = HA + HF;
  localparam int VS_START = VA + VF;
  localparam int STEP = 64;
  localparam logic [10:0] RST_O = {6'b000000, 1'b1, 1'b1, 3'b000};

  logic       clk;
  logic       rst_n;
  logic [1:0] vga_state;
  logic [1:0] audio_select;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, de, frame_tick, pwm_out;

  int checks = 0;
  int failures = 0;

  av_demo_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(2), .PWM_W(8), .ACC_W(16), .SEL_W(2), .STEP_BASE(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_state(vga_state), .audio_select(audio_select),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .de(de), .frame_tick(frame_tick), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame, frame count, latched mode, audio phase.
  int m_pix, m_fc, m_mode, m_acc, m_pc, m_duty;
  logic [5:0] e_rgb;
  logic e_hs, e_vs, e_de, e_ft, e_pwm;
  logic [10:0] exp_o, dut_o;
  assign exp_o = {e_rgb, e_hs, e_vs, e_de, e_ft, e_pwm};
  assign dut_o = {vga_r, vga_g, vga_b, hsync, vsync, de, frame_tick, pwm_out};

  function automatic logic [5:0] pix_rgb(int h, int v, int mode, int fc);
    int k, r, g, b;
    r = 0; g = 0; b = 0;
    if (h < HA && v < VA) begin
      case (mode)
        0: begin
          k = h / (HA / 8);
          r = ((k / 4) % 2 != 0) ? 3 : 0;
          g = ((k / 2) % 2 != 0) ? 3 : 0;
          b = (k % 2 != 0) ? 3 : 0;
        end
        1: begin
          r = (((h / 32) % 2) != ((v / 32) % 2)) ? 3 : 0;
          g = r; b = r;
        end
        2: begin
          r = (h / 16) % 4;
          g = r; b = r;
        end
        default: begin
          r = (((h + fc) % 256) / 16) % 4;
          g = (((v + fc) % 256) / 16) % 4;
          b = r ^ g;
        end
      endcase
    end
    return {2'(r), 2'(g), 2'(b)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pix <= 0; m_fc <= 0; m_mode <= 0; m_acc <= 0; m_pc <= 0; m_duty <= 0;
      e_rgb <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_ft <= 1'b0; e_pwm <= 1'b0;
    end else begin
      e_rgb <= pix_rgb(m_pix % HT, m_pix / HT, m_mode, m_fc);
      e_hs  <= !((m_pix % HT) >= HS_START && (m_pix % HT) < HS_START + HS);
      e_vs  <= !((m_pix / HT) >= VS_START && (m_pix / HT) < VS_START + VS);
      e_de  <= ((m_pix % HT) < HA) && ((m_pix / HT) < VA);
      e_ft  <= (m_pix == 0);
      e_pwm <= (audio_select != 2'd0) && (m_pc < m_duty);
      m_pix <= (m_pix + 1) % FRAME;
      if (m_pix == FRAME - 1) begin
        m_mode <= int'(vga_state);
        m_fc   <= (m_fc + 1) % 256;
      end
      if (m_pc == 255) m_duty <= m_acc / 256;
      m_pc <= (m_pc + 1) % 256;
      if (audio_select == 2'd0) m_acc <= 0;
      else if (m_pix % HT == HT - 1) m_acc <= (m_acc + int'(audio_select) * STEP) % 65536;
    end
  end

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    checks++;
    if (dut_o !== RST_O) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", dut_o, RST_O);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int hs_first, hs_second, hs_len, vs_first, vs_len, ft_first, ft_second;
    logic hs_prev, vs_prev;
    hs_first = -1; hs_second = -1; hs_len = 0; vs_first = -1; vs_len = 0;
    ft_first = -1; ft_second = -1; hs_prev = 1'b1; vs_prev = 1'b1;
    for (int n = 1; n <= FRAME + 2; n++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        failures++;
        $display("FAIL timing_out n=%0d: got %h expected %h", n, dut_o, exp_o);
      end
      if (!hsync && hs_prev) begin
        if (hs_first < 0) hs_first = n;
        else if (hs_second < 0) hs_second = n;
      end
      if (!hsync && hs_first >= 0 && hs_second < 0) hs_len++;
      if (!vsync && vs_prev && vs_first < 0) vs_first = n;
      if (!vsync) vs_len++;
      if (frame_tick) begin
        if (ft_first < 0) ft_first = n;
        else if (ft_second < 0) ft_second = n;
      end
      hs_prev = hsync;
      vs_prev = vsync;
    end
    checks++;
    if (hs_first != HS_START + 1) begin failures++; $display("FAIL hsync_start: got %0d expected %0d", hs_first, HS_START + 1); end
    checks++;
    if (hs_len != HS) begin failures++; $display("FAIL hsync_width: got %0d expected %0d", hs_len, HS); end
    checks++;
    if (hs_second - hs_first != HT) begin failures++; $display("FAIL hsync_period: got %0d expected %0d", hs_second - hs_first, HT); end
    checks++;
    if (vs_first != VS_START * HT + 1) begin failures++; $display("FAIL vsync_start: got %0d expected %0d", vs_first, VS_START * HT + 1); end
    checks++;
    if (vs_len != VS * HT) begin failures++; $display("FAIL vsync_width: got %0d expected %0d", vs_len, VS * HT); end
    checks++;
    if (ft_first != 1) begin failures++; $display("FAIL tick_first: got %0d expected 1", ft_first); end
    checks++;
    if (ft_second - ft_first != FRAME) begin failures++; $display("FAIL tick_period: got %0d expected %0d", ft_second - ft_first, FRAME); end
  endtask

  task automatic test_bars();
    int hpos [5];
    logic [5:0] want [5];
    bit ok;
    hpos = '{0, 8, 48, 63, 64};
    want = '{6'b000000, 6'b000011, 6'b111100, 6'b111111, 6'b000000};
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bars_sync: got no frame_tick expected one"); end
    for (int h = 0; h < HT; h++) begin
      if (h > 0) @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL bars_out h=%0d: got %h expected %h", h, dut_o, exp_o); end
      for (int j = 0; j < 5; j++) begin
        if (hpos[j] == h) begin
          checks++;
          if ({vga_r, vga_g, vga_b} !== want[j]) begin
            failures++;
            $display("FAIL bar_pixel h=%0d: got %b expected %b", h, {vga_r, vga_g, vga_b}, want[j]);
          end
        end
      end
      if (h == HA) begin
        checks++;
        if (de !== 1'b0) begin failures++; $display("FAIL bar_de_edge: got %b expected 0", de); end
      end
    end
  endtask

  task automatic test_mode_switch();
    int sw_line;
    bit ok;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL switch_sync: got no frame_tick expected one"); end
    sw_line = $urandom_range(2, VA - 2);
    for (int i = 1; i <= sw_line * HT + HT / 2; i++) begin
      @(negedge clk);
      if (i == HT / 2) vga_state = 2'($urandom_range(2, 3));
      if (i == sw_line * HT) vga_state = 2'd1;
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL switch_out i=%0d: got %h expected %h", i, dut_o, exp_o); end
    end
    ok = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL switch_tail i=%0d: got %h expected %h", i, dut_o, exp_o); end
      if (frame_tick === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL switch_next_frame: got no frame_tick expected one"); end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL checker_out i=%0d: got %h expected %h", i, dut_o, exp_o); end
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 6'b111111) begin failures++; $display("FAIL checker_32_0: got %b expected 111111", {vga_r, vga_g, vga_b}); end
    for (int i = 1; i <= 32 * HT; i++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL checker_out2 i=%0d: got %h expected %h", i, dut_o, exp_o); end
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 6'b000000) begin failures++; $display("FAIL checker_32_32: got %b expected 000000", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_scroll();
    bit ok;
    vga_state = 2'd3;
    sync_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL scroll_sync: got no frame_tick expected one"); end
    checks++;
    if (vga_r !== 2'd0) begin failures++; $display("FAIL scroll_origin_r: got %0d expected 0", vga_r); end
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL scroll_out i=%0d: got %h expected %h", i, dut_o, exp_o); end
      if (de === 1'b1) begin
        checks++;
        if (vga_b !== (vga_r ^ vga_g)) begin failures++; $display("FAIL scroll_xor i=%0d: got b=%0d expected %0d", i, vga_b, vga_r ^ vga_g); end
      end
    end
  endtask

  task automatic test_mute();
    audio_select = 2'd0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b0) begin failures++; $display("FAIL mute_pwm i=%0d: got %b expected 0", i, pwm_out); end
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL mute_out i=%0d: got %h expected %h", i, dut_o, exp_o); end
    end
  endtask

  task automatic test_tone();
    bit ok, seen;
    int dutyw, cnt;
    audio_select = 2'd1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_pc == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL tone_align: got no wrap expected one"); end
    seen = 1'b0;
    for (int w = 0; w < 8; w++) begin
      dutyw = m_duty;
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        checks++;
        if (dut_o !== exp_o) begin failures++; $display("FAIL tone_out w=%0d i=%0d: got %h expected %h", w, i, dut_o, exp_o); end
        if (pwm_out === 1'b1) cnt++;
      end
      checks++;
      if (cnt != dutyw) begin failures++; $display("FAIL pwm_duty w=%0d: got %0d expected %0d", w, cnt, dutyw); end
      if (!seen && cnt != 0) begin
        seen = 1'b1;
        checks++;
        if (cnt != 1) begin failures++; $display("FAIL pwm_first_step: got %0d expected 1", cnt); end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL pwm_rise: got 0 high cycles expected some"); end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 6; s++) begin
      audio_select = 2'($urandom_range(0, 3));
      vga_state = 2'($urandom_range(0, 3));
      len = $urandom_range(200, 600);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        checks++;
        if (dut_o !== exp_o) begin failures++; $display("FAIL random_out s=%0d i=%0d: got %h expected %h", s, i, dut_o, exp_o); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    audio_select = 2'd3;
    vga_state = 2'd2;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL premid_out i=%0d: got %h expected %h", i, dut_o, exp_o); end
      if (pwm_out === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_pwm_high: got no high expected one"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_o !== RST_O) begin failures++; $display("FAIL mid_reset_async: got %h expected %h", dut_o, RST_O); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 16; h++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin failures++; $display("FAIL postreset_out h=%0d: got %h expected %h", h, dut_o, exp_o); end
      if (h == 0) begin
        checks++;
        if (frame_tick !== 1'b1) begin failures++; $display("FAIL postreset_tick: got %b expected 1", frame_tick); end
      end
      if (h == 8) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== 6'b000011) begin failures++; $display("FAIL postreset_mode0: got %b expected 000011", {vga_r, vga_g, vga_b}); end
      end
    end
  endtask

  initial begin
    vga_state = 2'd0;
    audio_select = 2'd0;
    test_reset();
    test_timing();
    test_bars();
    test_mode_switch();
    test_scroll();
    test_mute();
    test_tone();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
